mem_port_arbiter: RTL and testbench

Shares one single-ported Memory between the processor's instruction-fetch port and its data port. Requesters use a req/gnt/rvalid handshake. The block serializes accesses onto mem_addr, mem_wdata, mem_read, mem_write and mem_rdata. It sits between processor and Memory, replacing the direct inst_addr/data_addr wiring. Data accesses have priority, and a starvation guard protects instruction fetch.

---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_arb_prio.sv | 35 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and defaults for the memory port arbiter.
//                Holds the arbiter state enum, the transaction owner enum,
//                default bus widths and the grant-vector bit positions used
//                by the priority logic.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int c_addr_w_def       = 32;
  localparam int c_data_w_def       = 32;
  localparam int c_mem_lat_def      = 1;
  localparam int c_starve_limit_def = 4;

  // Bit positions inside the two-bit grant vector
  localparam int c_gnt_if = 0;
  localparam int c_gnt_d  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch port, data port and memory bus seen by
//                the memory port arbiter.
//                master : processor + memory side (drives requests, payloads
//                         and mem_rdata)
//                slave  : the arbiter (drives gnt/rvalid/rdata, memory
//                         strobes/address/wdata and busy)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_prio
//  Description : Combinational priority selection between fetch and data
//                requests. Data wins unless fetch is pending and has already
//                been passed over STARVE_LIMIT times in a row.
//  Ports       : i_if_req, i_d_req - raw requests
//                i_starve_cnt      - consecutive data grants while fetch waits
//                o_gnt             - one-hot (or zero) grant vector
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = c_starve_limit_def,
  parameter int CNT_W        = 3
) (
  input  logic             i_if_req,
  input  logic             i_d_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic [1:0]       o_gnt
);

  logic w_if_forced;

  assign w_if_forced = i_if_req && (i_starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    o_gnt           = 2'b00;
    o_gnt[c_gnt_if] = i_if_req && (!i_d_req || w_if_forced);
    o_gnt[c_gnt_d]  = i_d_req && !w_if_forced;
  end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Serializes instruction-fetch and data accesses onto one
//                single-ported memory. Requests are accepted in IDLE or RESP
//                (back-to-back), reads hold mem_read for MEM_LAT cycles and
//                return data one cycle later, writes take a single cycle.
//  Ports       : clk      - system clock, rising edge
//                pc_reset - asynchronous active-high reset
//                bus      - fetch/data ports and memory bus (slave modport)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = c_addr_w_def,
  parameter int DATA_W       = c_data_w_def,
  parameter int MEM_LAT      = c_mem_lat_def,
  parameter int STARVE_LIMIT = c_starve_limit_def
) (
  input  logic                clk,
  input  logic                pc_reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int c_lat_w = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int c_cnt_w = $clog2(STARVE_LIMIT + 1);

  state_t              r_state, w_state_nxt;
  owner_t              r_owner, w_owner_nxt;
  logic [c_lat_w-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [c_cnt_w-1:0]  r_starve_cnt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_mem_read, w_mem_read_nxt;
  logic                r_mem_write, w_mem_write_nxt;
  logic [DATA_W-1:0]   r_if_rdata, r_d_rdata;
  logic                w_cap_if, w_cap_d;
  logic                w_accept;
  logic [1:0]          w_prio;
  logic                w_if_gnt, w_d_gnt;

  // Gated by reset so grants also read 0 while reset is held
  assign w_accept = ((r_state == IDLE) || (r_state == RESP)) && !pc_reset;

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (c_cnt_w)
  ) u_prio (
    .i_if_req     (bus.if_req),
    .i_d_req      (bus.d_req),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt        (w_prio)
  );

  assign w_if_gnt = w_accept && w_prio[c_gnt_if];
  assign w_d_gnt  = w_accept && w_prio[c_gnt_d];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_lat_cnt_nxt   = r_lat_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
    w_cap_if        = 1'b0;
    w_cap_d         = 1'b0;

    case (r_state)
      IDLE, RESP: begin
        w_state_nxt = IDLE;
        if (w_if_gnt) begin
          w_state_nxt    = RD;
          w_owner_nxt    = OWN_IF;
          w_lat_cnt_nxt  = c_lat_w'(1);
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = bus.if_addr;
        end else if (w_d_gnt) begin
          w_owner_nxt    = OWN_D;
          w_mem_addr_nxt = bus.d_addr;
          if (bus.d_we) begin
            w_state_nxt     = WR;
            w_mem_write_nxt = 1'b1;
            w_mem_wdata_nxt = bus.d_wdata;
          end else begin
            w_state_nxt    = RD;
            w_lat_cnt_nxt  = c_lat_w'(1);
            w_mem_read_nxt = 1'b1;
          end
        end
      end
      RD: begin
        // r_lat_cnt numbers the current mem_read cycle (1..MEM_LAT)
        if (r_lat_cnt == c_lat_w'(MEM_LAT)) begin
          w_state_nxt = RESP;
          w_cap_if    = (r_owner == OWN_IF);
          w_cap_d     = (r_owner == OWN_D);
        end else begin
          w_lat_cnt_nxt  = r_lat_cnt + 1'b1;
          w_mem_read_nxt = 1'b1;
        end
      end
      WR:      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_lat_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      if (w_cap_if) r_if_rdata <= bus.mem_rdata;
      if (w_cap_d)  r_d_rdata  <= bus.mem_rdata;
    end
  end

  // Counts data grants that overtook a waiting fetch; any fetch grant or a
  // cycle without a fetch request starts the count over.
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt != c_cnt_w'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = (r_state == RESP) && (r_owner == OWN_IF);
  assign bus.d_rvalid  = (r_state == RESP) && (r_owner == OWN_D);
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.busy      = (r_state != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter. Grants push the
//                expected read word (from a sequential memory model) into a
//                per-port queue; a monitor pops on every rvalid. A memory
//                model drives mem_rdata with valid data only in the last
//                mem_read cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MEM_LAT      = 3;
  localparam int STARVE_LIMIT = 4;
  localparam int TMO          = 60;

  logic clk      = 1'b0;
  logic pc_reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .pc_reset (pc_reset),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  exp_t        q_if[$];
  exp_t        q_d[$];
  logic [31:0] phys[logic [31:0]];
  logic [31:0] model[logic [31:0]];
  int          gnt_log[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, if_wait = 0, rv_seen = 0, rd_run = 0, wr_run = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : 32'h0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: valid data only in the MEM_LAT-th consecutive mem_read cycle
  initial forever begin
    @(negedge clk);
    if (pc_reset) begin
      rd_run = 0;
      wr_run = 0;
    end else begin
      if (bus.mem_read) begin
        rd_run++;
        bus.mem_rdata = (rd_run == MEM_LAT) ? phys_rd(bus.mem_addr) : $urandom();
      end else begin
        if (rd_run != 0) check("mem_read_len", rd_run, MEM_LAT);
        rd_run = 0;
        bus.mem_rdata = $urandom();
      end
      if (bus.mem_write) begin
        phys[bus.mem_addr] = bus.mem_wdata;
        wr_run++;
      end else begin
        if (wr_run != 0) check("mem_write_len", wr_run, 1);
        wr_run = 0;
      end
      if (bus.mem_read || bus.mem_write)
        check("rd_wr_excl", 64'(bus.mem_read && bus.mem_write), 0);
    end
  end

  // Monitor / scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!pc_reset) begin
      if (bus.if_rvalid || bus.d_rvalid) begin
        rv_seen++;
        check("rvalid_excl", 64'(bus.if_rvalid && bus.d_rvalid), 0);
      end
      if (bus.if_rvalid) begin
        if (q_if.size() == 0) check("if_rvalid_unexpected", 1, 0);
        else begin
          e = q_if.pop_front();
          check("if_rdata", bus.if_rdata, e.data);
          check("if_latency", 64'(cyc - e.gcyc), MEM_LAT + 1);
        end
      end
      if (bus.d_rvalid) begin
        if (q_d.size() == 0) check("d_rvalid_unexpected", 1, 0);
        else begin
          e = q_d.pop_front();
          check("d_rdata", bus.d_rdata, e.data);
          check("d_latency", 64'(cyc - e.gcyc), MEM_LAT + 1);
        end
      end
      if (bus.if_gnt || bus.d_gnt)
        check("gnt_excl", 64'(bus.if_gnt && bus.d_gnt), 0);
      if (bus.d_gnt) begin
        gnt_log.push_back(1);
        if (bus.if_req) check("d_gnt_while_if_starved", 64'(if_wait < STARVE_LIMIT), 1);
        if (bus.d_we) model[bus.d_addr] = bus.d_wdata;
        else q_d.push_back('{data: model_rd(bus.d_addr), gcyc: cyc});
      end
      if (bus.if_gnt) begin
        gnt_log.push_back(0);
        if (bus.d_req) check("if_gnt_over_d_wait", if_wait, STARVE_LIMIT);
        q_if.push_back('{data: model_rd(bus.if_addr), gcyc: cyc});
      end
      if (!bus.if_req || bus.if_gnt) if_wait = 0;
      else if (bus.d_gnt) if_wait++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the grant
  task automatic do_if(input logic [31:0] a, output int g);
    bit found = 0;
    g = -1;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    for (int k = 0; k < TMO && !found; k++) begin
      @(negedge clk);
      if (bus.if_gnt) begin
        found = 1;
        g = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!found) check("if_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.if_req  = 1'b0;
    bus.if_addr = $urandom();
  endtask

  task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      output int g);
    bit found = 0;
    g = -1;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    for (int k = 0; k < TMO && !found; k++) begin
      @(negedge clk);
      if (bus.d_gnt) begin
        found = 1;
        g = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!found) check("d_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'($urandom());
    bus.d_addr  = $urandom();
    bus.d_wdata = $urandom();
  endtask

  task automatic rst_zero_checks(input string tag);
    check({tag, "_ctl"}, {57'd0, bus.if_gnt, bus.if_rvalid, bus.d_gnt, bus.d_rvalid,
                          bus.mem_read, bus.mem_write, bus.busy}, 0);
    check({tag, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 0);
    check({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gd, gi, gd2, gi2, rv0, first_if, trail;
    logic [31:0] v;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 1; bus.d_we = 0;
    bus.d_addr = 32'h40; bus.d_wdata = 0; bus.mem_rdata = 0;
    for (int k = 0; k < 16; k++) begin
      v = $urandom();
      phys[32'(k * 4)]  = v;
      model[32'(k * 4)] = v;
    end
    phys[32'h10]  = 32'h8C220004;
    model[32'h10] = 32'h8C220004;

    // Reset state, with a data request held to show grants stay low
    idle(3);
    rst_zero_checks("reset");
    bus.d_req = 0;
    pc_reset  = 0;
    idle(2);

    // Single fetch
    do_if(32'h10, gi);
    @(negedge clk);
    check("fetch_mem_read", 64'(bus.mem_read), 1);
    check("fetch_mem_addr", bus.mem_addr, 32'h10);
    idle(MEM_LAT + 2);

    // Store
    do_d(1'b1, 32'h100, 32'hDEADBEEF, gd);
    @(negedge clk);
    check("store_strobes", {bus.mem_write, bus.mem_read}, 2'b10);
    check("store_addr_data", {bus.mem_addr, bus.mem_wdata}, {32'h100, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("store_done", {bus.mem_write, bus.busy}, 0);
    idle(2);

    // Contention: data first, fetch granted in the RESP cycle
    fork
      begin do_d(1'b0, 32'h100, 32'h0, gd); end
      begin do_if(32'h10, gi); end
    join
    check("contend_if_after_d", 64'(gi - gd), MEM_LAT + 1);
    idle(MEM_LAT + 3);

    // Starvation: continuous data reads against one pending fetch
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 10; k++) do_d(1'b0, 32'((k % 8) * 4), 32'h0, gd2);
      end
      begin do_if(32'h20, gi2); end
    join
    idle(MEM_LAT + 3);
    first_if = -1;
    trail = 0;
    for (int k = 0; k < gnt_log.size(); k++) begin
      if (gnt_log[k] == 0 && first_if < 0) first_if = k;
      else if (first_if >= 0 && gnt_log[k] == 1) trail++;
    end
    check("starve_d_before_if", 64'(first_if), STARVE_LIMIT);
    check("starve_d_after_if", 64'(trail), 10 - STARVE_LIMIT);

    // Randomized mixed traffic
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          idle($urandom_range(0, 4));
          do_if(32'($urandom_range(0, 7) * 4), gi);
        end
      end
      begin
        for (int k = 0; k < 50; k++) begin
          idle($urandom_range(0, 3));
          do_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom(), gd);
        end
      end
    join
    idle(MEM_LAT + 4);
    check("queues_drained", 64'(q_if.size() + q_d.size()), 0);

    // Reset in the middle of a fetch read
    do_if(32'h18, gi);
    check("rst_pre_mem_read", 64'(bus.mem_read), 1);
    #1;
    pc_reset = 1;
    #1;
    rst_zero_checks("midread_rst");
    q_if.delete();
    q_d.delete();
    rv0 = rv_seen;
    idle(2);
    pc_reset = 0;
    idle(MEM_LAT + 3);
    check("no_rvalid_after_rst", 64'(rv_seen - rv0), 0);
    check("busy_after_rst", 64'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
